// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered, zero-when-empty head word.
// Head is precomputed each cycle so consumers see a pure register output.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Push,
  input  logic [DATA_WIDTH-1:0]         Push_Data,
  input  logic                          Pop,
  output logic [DATA_WIDTH-1:0]         Head,
  output logic [$clog2(FIFO_DEPTH):0]   Count,
  output logic                          Full,
  output logic                          Empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         rd_next;
  logic [CW-1:0]         count_n;
  logic [DATA_WIDTH-1:0] head_n;
  logic                  push_ok;
  logic                  pop_ok;

  assign push_ok = Push && !Full;
  assign pop_ok  = Pop && !Empty;
  assign rd_next = rd_ptr + 1'b1;

  // After a pop the new head is either already stored, or (with one entry
  // left) it is the word being pushed in this same cycle.
  always_comb begin
    count_n = Count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
    head_n  = Head;
    if (count_n == '0) begin
      head_n = '0;
    end else if (pop_ok) begin
      head_n = (Count == CW'(1)) ? Push_Data : mem[rd_next];
    end else if (Empty) begin
      head_n = Push_Data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
      Head   <= '0;
      Full   <= 1'b0;
      Empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_next;
      Count <= count_n;
      Head  <= head_n;
      Full  <= (count_n == CW'(FIFO_DEPTH));
      Empty <= (count_n == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= Push_Data;
  end

endmodule

// File: rtl/demux_1x2_buffered.sv
// 1-to-2 stream demux: each input word is steered by IN_Sel into one of two
// output queues, so a stalled consumer only blocks words aimed at it.
module demux_1x2_buffered #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         IN_Data,
  input  logic                          IN_Sel,
  input  logic                          IN_Valid,
  output logic                          IN_Ready,
  output logic [DATA_WIDTH-1:0]         OUT_0,
  output logic                          OUT_0_Valid,
  input  logic                          OUT_0_Ready,
  output logic [DATA_WIDTH-1:0]         OUT_1,
  output logic                          OUT_1_Valid,
  input  logic                          OUT_1_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   Count_0,
  output logic [$clog2(FIFO_DEPTH):0]   Count_1
);

  logic                  full_0;
  logic                  full_1;
  logic                  empty_0;
  logic                  empty_1;
  logic [DATA_WIDTH-1:0] head_0;
  logic [DATA_WIDTH-1:0] head_1;
  logic                  push_0;
  logic                  push_1;
  logic                  pop_0;
  logic                  pop_1;

  // Ready depends only on registered full flags: no consumer-to-producer path.
  assign IN_Ready = IN_Sel ? !full_1 : !full_0;

  assign push_0 = IN_Valid && IN_Ready && !IN_Sel;
  assign push_1 = IN_Valid && IN_Ready &&  IN_Sel;
  assign pop_0  = OUT_0_Valid && OUT_0_Ready;
  assign pop_1  = OUT_1_Valid && OUT_1_Ready;

  assign OUT_0_Valid = !empty_0;
  assign OUT_1_Valid = !empty_1;
  assign OUT_0       = empty_0 ? '0 : head_0;
  assign OUT_1       = empty_1 ? '0 : head_1;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_0 (
    .CLK       (CLK),
    .RST       (RST),
    .Push      (push_0),
    .Push_Data (IN_Data),
    .Pop       (pop_0),
    .Head      (head_0),
    .Count     (Count_0),
    .Full      (full_0),
    .Empty     (empty_0)
  );

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_1 (
    .CLK       (CLK),
    .RST       (RST),
    .Push      (push_1),
    .Push_Data (IN_Data),
    .Pop       (pop_1),
    .Head      (head_1),
    .Count     (Count_1),
    .Full      (full_1),
    .Empty     (empty_1)
  );

endmodule

// File: tb/tb_demux_1x2_buffered.sv
// Scoreboard bench for demux_1x2_buffered: per-queue expected words are
// queued on accepted pushes and compared against the outputs every cycle.
module tb_demux_1x2_buffered;

  localparam int DW = 32;
  localparam int D  = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] IN_Data;
  logic          IN_Sel;
  logic          IN_Valid;
  logic          IN_Ready;
  logic [DW-1:0] OUT_0;
  logic          OUT_0_Valid;
  logic          OUT_0_Ready;
  logic [DW-1:0] OUT_1;
  logic          OUT_1_Valid;
  logic          OUT_1_Ready;
  logic [1:0]    Count_0;
  logic [1:0]    Count_1;

  int n_checks = 0;
  int n_pass   = 0;
  bit model_ok = 0;
  bit acc      = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  demux_1x2_buffered #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_Data     (IN_Data),
    .IN_Sel      (IN_Sel),
    .IN_Valid    (IN_Valid),
    .IN_Ready    (IN_Ready),
    .OUT_0       (OUT_0),
    .OUT_0_Valid (OUT_0_Valid),
    .OUT_0_Ready (OUT_0_Ready),
    .OUT_1       (OUT_1),
    .OUT_1_Valid (OUT_1_Valid),
    .OUT_1_Ready (OUT_1_Ready),
    .Count_0     (Count_0),
    .Count_1     (Count_1)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Model state is compared first, then advanced for the coming rising edge.
  always @(negedge CLK) begin
    int  s0;
    int  s1;
    bit  p0;
    bit  p1;
    bit  psh;
    s0 = exp_q0.size();
    s1 = exp_q1.size();
    if (model_ok) begin
      check("count_0", 32'(Count_0), s0);
      check("count_1", 32'(Count_1), s1);
      check("valid_0", 32'(OUT_0_Valid), (s0 != 0) ? 1 : 0);
      check("valid_1", 32'(OUT_1_Valid), (s1 != 0) ? 1 : 0);
      check("out_0", OUT_0, (s0 != 0) ? exp_q0[0] : 32'h0);
      check("out_1", OUT_1, (s1 != 0) ? exp_q1[0] : 32'h0);
      check("in_ready", 32'(IN_Ready), (IN_Sel ? (s1 < D) : (s0 < D)) ? 1 : 0);
    end
    if (RST) begin
      exp_q0.delete();
      exp_q1.delete();
      model_ok = 1;
    end else if (model_ok) begin
      p0  = (s0 != 0) && OUT_0_Ready;
      p1  = (s1 != 0) && OUT_1_Ready;
      psh = IN_Valid && (IN_Sel ? (s1 < D) : (s0 < D));
      if (p0) void'(exp_q0.pop_front());
      if (p1) void'(exp_q1.pop_front());
      if (psh) begin
        if (IN_Sel) exp_q1.push_back(IN_Data);
        else        exp_q0.push_back(IN_Data);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic s);
    bit ok = 0;
    IN_Data  = d;
    IN_Sel   = s;
    IN_Valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge CLK);
      ok = IN_Ready;
    end
    if (!ok) check("send_timeout", 32'(ok), 1);
    @(posedge CLK);
    #1;
    IN_Valid = 1'b0;
  endtask

  initial begin
    RST         = 1'b1;
    IN_Valid    = 1'b1;
    IN_Data     = 32'hDEAD_BEEF;
    IN_Sel      = 1'b0;
    OUT_0_Ready = 1'b1;
    OUT_1_Ready = 1'b1;
    step(2);
    RST      = 1'b0;
    IN_Valid = 1'b0;

    // steering and order
    send(32'hA0, 1'b0);
    send(32'hB1, 1'b1);
    send(32'hA2, 1'b0);
    step(3);

    // fill queue 0, other queue stays open, third word is held
    OUT_0_Ready = 1'b0;
    send(32'h10, 1'b0);
    send(32'h11, 1'b0);
    send(32'hC3, 1'b1);
    IN_Data  = 32'h12;
    IN_Sel   = 1'b0;
    IN_Valid = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("held_ready", 32'(IN_Ready), 0);
      check("held_count0", 32'(Count_0), 2);
    end
    @(posedge CLK);
    #1;
    OUT_0_Ready = 1'b1;
    send(32'h12, 1'b0);
    step(4);

    // simultaneous push/pop on queue 1 across pointer wraps
    OUT_1_Ready = 1'b0;
    send(32'h20, 1'b1);
    OUT_1_Ready = 1'b1;
    for (int i = 0; i < 6; i++) send(32'h21 + i, 1'b1);
    step(3);

    // random traffic with producer hold
    for (int i = 0; i < 300; i++) begin
      if (!IN_Valid || acc) begin
        IN_Valid = ($urandom_range(0, 3) != 0);
        IN_Sel   = 1'($urandom_range(0, 1));
        IN_Data  = $urandom;
      end
      OUT_0_Ready = ($urandom_range(0, 2) != 0);
      OUT_1_Ready = 1'($urandom_range(0, 1));
      @(negedge CLK);
      acc = IN_Valid && IN_Ready;
      @(posedge CLK);
      #1;
    end
    IN_Valid    = 1'b0;
    OUT_0_Ready = 1'b1;
    OUT_1_Ready = 1'b1;
    step(5);

    // reset with both queues full
    OUT_0_Ready = 1'b0;
    OUT_1_Ready = 1'b0;
    send(32'h30, 1'b0);
    send(32'h31, 1'b0);
    send(32'h40, 1'b1);
    send(32'h41, 1'b1);
    RST = 1'b1;
    step(1);
    RST         = 1'b0;
    OUT_0_Ready = 1'b1;
    OUT_1_Ready = 1'b1;
    step(5);

    check("final_count_0", 32'(Count_0), 0);
    check("final_count_1", 32'(Count_1), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
